instr_aligner: RTL and testbench

- Sits between the instruction fetch stage (OBI fetch responses) and the ID stage.
- Buffers word-aligned fetched data in a small FIFO and re-aligns it into 16-bit (compressed) or 32-bit instructions. This includes 32-bit instructions that straddle two words and targets at PC[1]=1.
- Supplies ID with an instruction, its PC, a compressed flag and a valid/ready handshake.
- Drops stale in-flight fetch responses after a redirect (branch/jump/trap/mret).

---
 rtl/core_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/instr_aligner.sv | 75 +++++++
 tb/tb_instr_aligner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared fetch/align constants for the instruction aligner.
package core_pkg;
  localparam int INSTR_LEN_C = 16;
  localparam logic [1:0] OPCODE_32B = 2'b11;
  localparam int FETCH_FIFO_DEPTH = 2;
  function automatic logic is_32b(input logic [1:0] op);
    return op == OPCODE_32B;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: word FIFO with push/pop/flush, count, full/empty and head/head+1 reads.
//   clk_i, rst_n_i : clock, async active-low reset
//   push, wdata    : write a word (ignored when full)
//   pop            : drop the head word (ignored when empty)
//   flush          : empty the FIFO
//   head, next_lo  : head word and low half of the word after it
//   count, full, empty : occupancy
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   wdata,
  output logic [31:0]   head,
  output logic [15:0]   next_lo,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [31:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd];
  assign next_lo = mem[inc(rd)][15:0];
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr] <= wdata;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= inc(wr);
      if (do_pop) rd <= inc(rd);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instr_aligner.sv
// instr_aligner: buffers fetched words and re-aligns them into 16/32-bit instructions for ID.
//   clk_i, rst_n_i         : clock, async active-low reset
//   boot_addr_i            : boot word address (reset PC = {boot_addr_i, 2'b00})
//   fetch_valid_i/addr/rdata, fetch_ready_o : fetch response stream
//   flush_i, flush_pc_i    : redirect, discards all buffered state
//   instr_valid_o, instr_o, pc_o, is_compressed_o, instr_ready_i : ID handshake
module instr_aligner
  import core_pkg::*;
#(
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [29:0] boot_addr_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_addr_i,
  input  logic [31:0] fetch_rdata_i,
  output logic        fetch_ready_o,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        is_compressed_o,
  input  logic        instr_ready_i
);
  if (DEPTH < 2) begin : g_bad_depth
    $error("instr_aligner: DEPTH must be >= 2");
  end
  logic [31:0] pc_q, exp_q, head;
  logic [15:0] next_lo, half;
  logic [CW-1:0] count;
  logic full, empty, lo, wide, valid, pop_req, consume, push;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (push),
    .pop     (consume && pop_req),
    .flush   (flush_i),
    .wdata   (fetch_rdata_i),
    .head    (head),
    .next_lo (next_lo),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );
  // A straddling 32-bit instruction (upper half of head) also needs the next word.
  always_comb begin
    lo = !pc_q[1];
    half = lo ? head[15:0] : head[31:16];
    wide = is_32b(half[1:0]);
    valid = (wide && !lo) ? count >= CW'(2) : !empty;
    instr_o = !valid ? '0 : wide ? (lo ? head : {next_lo, head[31:16]}) : {{INSTR_LEN_C{1'b0}}, half};
    pop_req = wide || !lo;
  end
  assign consume = valid && instr_ready_i && !flush_i;
  assign push = fetch_valid_i && !full && !flush_i && fetch_addr_i == exp_q;
  assign fetch_ready_o = !full;
  assign instr_valid_o = valid;
  assign is_compressed_o = valid && !wide;
  assign pc_o = pc_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q <= {boot_addr_i, 2'b00};
      exp_q <= {boot_addr_i, 2'b00};
    end else if (flush_i) begin
      pc_q <= flush_pc_i & ~32'd1;
      exp_q <= flush_pc_i & ~32'd3;
    end else begin
      if (consume) pc_q <= pc_q + (wide ? 32'd4 : 32'd2);
      if (push) exp_q <= exp_q + 32'd4;
    end
  end
endmodule

// File: tb/tb_instr_aligner.sv
// tb_instr_aligner: directed plus random checks of instr_aligner against a halfword-stream model.
module tb_instr_aligner;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 1;
  logic [29:0] boot = 30'h20;
  logic fv = 0, flush = 0, rdy = 1;
  logic [31:0] fa = 0, fd = 0, fpc = 0;
  logic ready, ivalid, icomp;
  logic [31:0] instr, pc;
  int total = 0, bad = 0;
  logic [15:0] hq[$];
  logic [31:0] mpc, mexp;
  logic [31:0] s_instr, s_pc;

  instr_aligner #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .boot_addr_i(boot),
    .fetch_valid_i(fv), .fetch_addr_i(fa), .fetch_rdata_i(fd), .fetch_ready_o(ready),
    .flush_i(flush), .flush_pc_i(fpc),
    .instr_valid_o(ivalid), .instr_o(instr), .pc_o(pc), .is_compressed_o(icomp),
    .instr_ready_i(rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: hq holds both halves of every buffered word, oldest first; the
  // instruction starts at half index mpc[1] and a low opcode of 11 means 32-bit.
  task automatic model_out(output logic v, output logic [31:0] ins, output logic c, output int len);
    int idx;
    idx = int'(mpc[1]);
    v = 0; ins = 0; c = 0; len = 0;
    if (hq.size() > idx) begin
      if (hq[idx][1:0] != 2'b11) begin
        v = 1; ins = {16'h0, hq[idx]}; c = 1; len = 1;
      end else if (hq.size() > idx + 1) begin
        v = 1; ins = {hq[idx+1], hq[idx]}; len = 2;
      end
    end
  endtask

  task automatic check();
    logic v, c;
    logic [31:0] ins;
    int len;
    model_out(v, ins, c, len);
    chk("valid", 32'(ivalid), 32'(v));
    chk("instr", instr, ins);
    chk("pc", pc, mpc);
    chk("compressed", 32'(icomp), 32'(c));
    chk("ready", 32'(ready), 32'(hq.size() / 2 < DEPTH));
  endtask

  task automatic model_reset();
    hq.delete();
    mpc = {boot, 2'b00};
    mexp = {boot, 2'b00};
  endtask

  task automatic step();
    logic v, c, npush, ncons;
    logic [31:0] ins;
    int len, nidx;
    model_out(v, ins, c, len);
    npush = fv && (hq.size() / 2 < DEPTH) && !flush && fa == mexp;
    ncons = v && rdy && !flush;
    @(posedge clk);
    #1;
    if (flush) begin
      hq.delete();
      mpc = {fpc[31:1], 1'b0};
      mexp = {fpc[31:2], 2'b00};
    end else begin
      if (ncons) begin
        nidx = int'(mpc[1]) + len;
        repeat (nidx / 2) begin
          void'(hq.pop_front());
          void'(hq.pop_front());
        end
        mpc = mpc + 32'(2 * len);
      end
      if (npush) begin
        hq.push_back(fd[15:0]);
        hq.push_back(fd[31:16]);
        mexp = mexp + 4;
      end
    end
    check();
  endtask

  task automatic idle();
    fv = 0; flush = 0;
  endtask

  initial begin
    int n;
    #2 rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    check();
    chk("reset_pc", pc, 32'h80);
    rst_n = 1;
    fv = 1; fa = 32'h84; fd = 32'h1234_5678;
    step();
    chk("mismatch_drop", 32'(ivalid), 32'd0);
    fa = 32'h80; fd = 32'h4501_4081;
    step();
    idle();
    chk("c1_instr", instr, 32'h4081);
    step();
    chk("c2_instr", instr, 32'h4501);
    chk("c2_pc", pc, 32'h82);
    step();
    chk("c_drained", 32'(ivalid), 32'd0);
    flush = 1; fpc = 32'h80;
    step();
    flush = 0; fv = 1; fa = 32'h80; fd = 32'h0513_4081;
    step();
    idle();
    chk("s1_instr", instr, 32'h4081);
    step();
    chk("straddle_wait", 32'(ivalid), 32'd0);
    chk("straddle_pc", pc, 32'h82);
    step();
    fv = 1; fa = 32'h84; fd = 32'h4081_00A0;
    step();
    idle();
    chk("straddle_instr", instr, 32'h00A0_0513);
    chk("straddle_comp", 32'(icomp), 32'd0);
    step();
    chk("s3_instr", instr, 32'h4081);
    chk("s3_pc", pc, 32'h86);
    step();
    fv = 1; fa = 32'h88; fd = 32'hDEAD_BEEF; flush = 1; fpc = 32'h103;
    step();
    flush = 0;
    step();
    chk("stale_drop", 32'(ivalid), 32'd0);
    chk("flush_pc", pc, 32'h102);
    fa = 32'h100; fd = 32'h4505_1111;
    step();
    idle();
    chk("f_instr", instr, 32'h4505);
    chk("f_pc", pc, 32'h102);
    step();
    rdy = 0; fv = 1;
    for (int i = 0; i < 5; i++) begin
      fa = mexp; fd = 32'h0001_0001 * (i + 3) | 32'h0003_0000;
      step();
      if (i == 0) begin
        s_instr = instr; s_pc = pc;
      end else begin
        chk("stall_instr", instr, s_instr);
        chk("stall_pc", pc, s_pc);
      end
    end
    chk("stall_full", 32'(ready), 32'd0);
    idle(); rdy = 1;
    n = 0;
    while (ivalid && n < 20) begin
      step();
      n++;
    end
    chk("drain_bound", 32'(ivalid), 32'd0);
    fv = 1; fa = mexp; fd = 32'h0000_4081;
    step();
    fa = mexp; fd = 32'h1111_2222; flush = 1; fpc = 32'h200;
    step();
    idle();
    chk("coinc_valid", 32'(ivalid), 32'd0);
    chk("coinc_ready", 32'(ready), 32'd1);
    chk("coinc_pc", pc, 32'h200);
    fv = 1; fa = mexp; fd = 32'h0513_4081;
    step();
    fa = mexp; fd = 32'h4081_00A0;
    step();
    #1 rst_n = 0;
    model_reset();
    #1;
    chk("arst_valid", 32'(ivalid), 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_pc", pc, 32'h80);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_comp", 32'(icomp), 32'd0);
    idle();
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    check();
    for (int i = 0; i < 600; i++) begin
      fv = ($urandom % 4) != 0;
      fa = ($urandom % 8 == 0) ? mexp + 4 : mexp;
      fd = $urandom;
      rdy = ($urandom % 4) != 0;
      flush = ($urandom % 32) == 0;
      fpc = ($urandom % 3 == 0) ? 32'hFFFF_FFF8 + ($urandom % 8) : $urandom;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
